// File: rtl/aurora_pkg.sv
// Shared types and constant words for the Aurora lane transmit scheduler.
package aurora_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned K_W    = 2;
    localparam int unsigned WORD_W = K_W + DATA_W;

    // Lane word: K flags per byte followed by the two bytes.
    typedef struct packed {
        logic [K_W-1:0]    kflags;
        logic [DATA_W-1:0] bytes;
    } tx_word_t;

    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_INIT = 2'd1,
        SRC_CC   = 2'd2,
        SRC_DATA = 2'd3
    } tx_src_t;

    // K28.5 / D10.2
    localparam tx_word_t IDLE_WORD = '{kflags: 2'b10, bytes: 16'hBC4A};
    // K28.7 / K28.7
    localparam tx_word_t CC_WORD   = '{kflags: 2'b11, bytes: 16'hFCFC};

    function automatic tx_word_t make_data_word(input logic [DATA_W-1:0] payload);
        return '{kflags: 2'b00, bytes: payload};
    endfunction

endpackage

// File: rtl/aurora_cc_timer.sv
// Clock-compensation timer: free-running period counter plus burst length counter.
module aurora_cc_timer #(
    parameter int unsigned CC_PERIOD = 5000,
    parameter int unsigned CC_LEN    = 6
) (
    input  logic clk,
    input  logic rst,
    output logic cc_start,
    output logic cc_busy
);

    localparam int unsigned CNT_W   = $clog2(CC_PERIOD);
    localparam int unsigned BURST_W = $clog2(CC_LEN + 1);

    logic [CNT_W-1:0]   cnt;
    logic [BURST_W-1:0] burst_cnt;

    assign cc_start = (cnt == CNT_W'(CC_PERIOD - 1));

    // Burst words still owed after the current cycle; the start cycle itself is word one.
    assign cc_busy = (burst_cnt > BURST_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            burst_cnt <= '0;
        end else begin
            cnt <= cc_start ? '0 : cnt + CNT_W'(1);
            if (cc_start) begin
                burst_cnt <= BURST_W'(CC_LEN - 1);
            end else if (burst_cnt != '0) begin
                burst_cnt <= burst_cnt - BURST_W'(1);
            end
        end
    end

endmodule

// File: rtl/aurora_tx_sched.sv
// Aurora lane transmit scheduler: arbitrates CC bursts, init ordered sets, user data and idles.
// Clock compensation is compiled in only when AURORA_TX_CLK_COMP_EN is defined.
module aurora_tx_sched
    import aurora_pkg::*;
#(
    parameter int unsigned CC_PERIOD = 5000,
    parameter int unsigned CC_LEN    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  os_valid,
    input  logic [WORD_W-1:0]     os_word,
    input  logic                  init_finished,
    input  logic                  data_valid,
    input  logic [DATA_W-1:0]     data,
    output logic                  data_ready,
    output logic [WORD_W-1:0]     tx_word,
    output tx_src_t               tx_src,
    output logic                  cc_active
);

    if (CC_LEN < 1 || CC_PERIOD < CC_LEN + 2) begin : g_bad_cfg
        $error("aurora_tx_sched: CC_LEN must be >= 1 and CC_PERIOD >= CC_LEN + 2");
    end

`ifdef AURORA_TX_CLK_COMP_EN
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_CC} state_t;
`else
    typedef enum logic {ST_INIT, ST_RUN} state_t;
`endif

    state_t   state;
    state_t   state_next;
    logic     cc_start;
    logic     cc_sel;
    tx_word_t sel_word;
    tx_src_t  sel_src;

`ifdef AURORA_TX_CLK_COMP_EN
    logic cc_busy;

    aurora_cc_timer #(
        .CC_PERIOD (CC_PERIOD),
        .CC_LEN    (CC_LEN)
    ) u_cc_timer (
        .clk      (clk),
        .rst      (rst),
        .cc_start (cc_start),
        .cc_busy  (cc_busy)
    );

    assign cc_sel = cc_start || (state == ST_CC);
`else
    assign cc_start = 1'b0;
    assign cc_sel   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, word selection and the combinational ready.
    always_comb begin
        state_next = state;
        sel_word   = IDLE_WORD;
        sel_src    = SRC_IDLE;
        data_ready = 1'b0;

        data_ready = (state == ST_RUN) && init_finished && !cc_start && !rst;

        case (state)
            ST_INIT: if (init_finished) state_next = ST_RUN;
            ST_RUN:  if (!init_finished) state_next = ST_INIT;
`ifdef AURORA_TX_CLK_COMP_EN
            ST_CC:   if (!cc_busy) state_next = init_finished ? ST_RUN : ST_INIT;
`endif
            default: state_next = ST_INIT;
        endcase

`ifdef AURORA_TX_CLK_COMP_EN
        // A single-word burst is finished by the start cycle alone.
        if (cc_start) begin
            if (CC_LEN > 1) begin
                state_next = ST_CC;
            end else begin
                state_next = init_finished ? ST_RUN : ST_INIT;
            end
        end
`endif

        // Ordered sets outside ST_INIT are dropped; upstream repeats them.
        if (cc_sel) begin
            sel_word = CC_WORD;
            sel_src  = SRC_CC;
        end else if ((state == ST_INIT) && os_valid && !init_finished) begin
            sel_word = tx_word_t'(os_word);
            sel_src  = SRC_INIT;
        end else if (data_valid && data_ready) begin
            sel_word = make_data_word(data);
            sel_src  = SRC_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_word   <= IDLE_WORD;
            tx_src    <= SRC_IDLE;
            cc_active <= 1'b0;
        end else begin
            tx_word   <= sel_word;
            tx_src    <= sel_src;
            cc_active <= cc_sel;
        end
    end

endmodule

// File: tb/tb_aurora_tx_sched.sv
// Directed bench for aurora_tx_sched; adapts expected CC timing to AURORA_TX_CLK_COMP_EN.
module tb_aurora_tx_sched;
    import aurora_pkg::*;

    localparam int CC_PERIOD = 20;
    localparam int CC_LEN    = 4;
`ifdef AURORA_TX_CLK_COMP_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif
    localparam logic [17:0] IDLE_W = 18'h2BC4A;
    localparam logic [17:0] CC_W   = 18'h3FCFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        os_valid;
    logic [17:0] os_word;
    logic        init_finished;
    logic        data_valid;
    logic [15:0] data;
    logic        data_ready;
    logic [17:0] tx_word;
    tx_src_t     tx_src;
    logic        cc_active;

    int          checks = 0;
    int          errors = 0;
    int          k = 0;
    logic [17:0] prev_os;
    logic [15:0] sent;

    always #5 clk = ~clk;

    aurora_tx_sched #(
        .CC_PERIOD (CC_PERIOD),
        .CC_LEN    (CC_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .os_valid      (os_valid),
        .os_word       (os_word),
        .init_finished (init_finished),
        .data_valid    (data_valid),
        .data          (data),
        .data_ready    (data_ready),
        .tx_word       (tx_word),
        .tx_src        (tx_src),
        .cc_active     (cc_active)
    );

    // Output index kk (edges since release) carries a CC word.
    function automatic bit cc_out(input int kk);
        return CC_EN && (kk >= CC_PERIOD) && ((kk % CC_PERIOD) < CC_LEN);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic check_out(input logic [17:0] w, input tx_src_t s, input bit cc);
        check("tx_word", 32'(tx_word), 32'(w));
        check("tx_src", 32'(tx_src), 32'(s));
        check("cc_active", 32'(cc_active), 32'(cc));
    endtask

    task automatic run_init(input int until_k);
        os_valid = 1'b1;
        while (k < until_k) begin
            os_word = {2'b01, 8'hBC, 8'(k)};
            prev_os = os_word;
            #1;
            check("ready_init", 32'(data_ready), 32'(0));
            tick();
            if (cc_out(k)) check_out(CC_W, SRC_CC, 1'b1);
            else           check_out(prev_os, SRC_INIT, 1'b0);
        end
    endtask

    task automatic run_data(input int until_k, input int run_from);
        bit hs;
        while (k < until_k) begin
            hs   = (k >= run_from) && !cc_out(k + 1);
            sent = data;
            #1;
            check("ready_data", 32'(data_ready), 32'(hs));
            tick();
            if (cc_out(k))  check_out(CC_W, SRC_CC, 1'b1);
            else if (hs)    check_out({2'b00, sent}, SRC_DATA, 1'b0);
            else            check_out(IDLE_W, SRC_IDLE, 1'b0);
            if (hs) data = data + 16'd1;
        end
    endtask

    initial begin
        rst           = 1'b1;
        os_valid      = 1'b0;
        os_word       = 18'h0;
        init_finished = 1'b1;
        data_valid    = 1'b1;
        data          = 16'h1234;
        repeat (3) tick();
        check_out(IDLE_W, SRC_IDLE, 1'b0);
        check("ready_rst", 32'(data_ready), 32'(0));

        // Init ordered sets with CC bursts from 19 cycles after release.
        init_finished = 1'b0;
        data_valid    = 1'b0;
        rst           = 1'b0;
        k             = 0;
        run_init(45);

        // User data stream, stalled around each burst.
        init_finished = 1'b1;
        data_valid    = 1'b1;
        data          = 16'h0001;
        run_data(100, 46);

        // init_finished drops inside the burst at output 100.
        init_finished = 1'b0;
        repeat (8) begin
            os_word = {2'b01, 8'hBC, 8'(k)};
            prev_os = os_word;
            #1;
            check("ready_drop", 32'(data_ready), 32'(0));
            tick();
            if (CC_EN && k <= 103)       check_out(CC_W, SRC_CC, 1'b1);
            else if (!CC_EN && k == 101) check_out(IDLE_W, SRC_IDLE, 1'b0);
            else                         check_out(prev_os, SRC_INIT, 1'b0);
        end

        // Reset lands while the second CC word of the burst at 120 is on the wire.
        run_init(121);
        rst = 1'b1;
        #1;
        check("ready_in_rst", 32'(data_ready), 32'(0));
        tick();
        check_out(IDLE_W, SRC_IDLE, 1'b0);
        rst = 1'b0;
        k   = 0;
        run_init(30);

        // Long continuous data run.
        init_finished = 1'b1;
        data_valid    = 1'b1;
        data          = 16'hA000;
        run_data(140, 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aurora_tx_sched.md
AURORA_TX_SCHED -- requirements
Module: aurora_tx_sched

Interface
REQ-001 Parameter CC_PERIOD, 5000, number of cycles between starts of successive clock-compensation (CC) bursts; SHALL be >= CC_LEN+2.
REQ-002 Parameter CC_LEN, 6, number of consecutive CC words sent per burst; SHALL be >= 1.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port os_valid  input  1  channel initialization has an ordered-set word to send this cycle.
REQ-006 Port os_word  input  18  ordered-set word: [17:16] K flags, [15:0] two bytes.
REQ-007 Port init_finished  input  1  channel initialization complete; user data allowed.
REQ-008 Port data_valid  input  1  user word offered.
REQ-009 Port data  input  16  user payload word.
REQ-010 Port data_ready  output  1  user word accepted when data_valid && data_ready.
REQ-011 Port tx_word  output  18  word driven to lane encoder, same layout as os_word.
REQ-012 Port tx_src  output  2  tx_src_t source of current tx_word: SRC_IDLE, SRC_INIT, SRC_CC, SRC_DATA.
REQ-013 Port cc_active  output  1  high while tx_word is a CC word.

Function
REQ-014 tx_word, tx_src and cc_active SHALL be registered; a word selected in cycle N appears at the outputs in cycle N+1.
REQ-015 Per-cycle priority SHALL be: CC > ordered set (os_valid && !init_finished) > user data (init_finished && data_valid) > idle.
REQ-016 The FSM SHALL have states ST_INIT (init_finished low), ST_RUN (init_finished high) and ST_CC (burst in progress).
REQ-017 The cycle counter SHALL increment every cycle from 0, wrap to 0 after CC_PERIOD-1, and raise cc_start on the wrap cycle.
REQ-018 On cc_start, the FSM SHALL enter ST_CC from either state; CC words SHALL appear for exactly CC_LEN consecutive output cycles.
REQ-019 In ST_CC, changes on init_finished or os_valid SHALL NOT shorten the burst; on completion the FSM SHALL go to ST_RUN if init_finished is high, otherwise ST_INIT.
REQ-020 data_ready SHALL be combinational: high only in ST_RUN, with init_finished high and cc_start low.
REQ-021 A user word SHALL be consumed only on data_valid && data_ready; tx_word in the next cycle SHALL be {2'b00, data} with tx_src = SRC_DATA.
REQ-022 An ordered set offered during CC or in ST_RUN SHALL be dropped; the upstream init logic is responsible for repeating it.
REQ-023 If init_finished falls in ST_RUN, data_ready SHALL drop in the same cycle and the FSM SHALL enter ST_INIT next cycle.
REQ-024 An idle cycle SHALL output IDLE_WORD with tx_src = SRC_IDLE.
REQ-025 A CC cycle SHALL output CC_WORD with tx_src = SRC_CC and cc_active = 1.

Reset
REQ-026 While rst is high: state ST_INIT, counter 0, burst count 0, tx_word IDLE_WORD, tx_src SRC_IDLE, cc_active 0, data_ready 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst; the first output after reset is IDLE_WORD.
REQ-028 After reset, the first cc_start SHALL occur CC_PERIOD-1 cycles after rst deasserts.

Configuration
REQ-029 Macro AURORA_TX_CLK_COMP_EN SHALL compile in the CC counter, ST_CC and CC_LEN burst logic.
REQ-030 Without AURORA_TX_CLK_COMP_EN: no counter or ST_CC, cc_start is constant 0, cc_active is tied 0, SRC_CC is never produced, and parameters are accepted but unused.

Structure
REQ-031 aurora_pkg SHALL hold tx_src_t, the 18-bit tx_word_t, IDLE_WORD (K28.5/D10.2, K=2'b10) and CC_WORD (K28.7/K28.7, K=2'b11).
REQ-032 The CC period/burst counter SHALL be a sub-module aurora_cc_timer (outputs cc_start, cc_busy) instantiated only under the macro.

Verification (bench CC_PERIOD=20, CC_LEN=4, macro defined unless stated)
REQ-033 Release rst, init_finished=0, os_valid=1 constant -> first cc_start 19 cycles after release; output tx_src=SRC_INIT each cycle except 4 consecutive SRC_CC cycles starting 1 cycle after each cc_start, then every 20 cycles.
REQ-034 init_finished=1, data_valid=1 with incrementing data 0x0001.. -> tx_word 0x0001,0x0002,... 1 cycle later; data_ready=0 on each cc_start cycle and during the burst; no word lost or duplicated.
REQ-035 Drop init_finished during a CC burst -> burst still 4 words, then SRC_INIT/SRC_IDLE; data_ready stays 0.
REQ-036 Assert rst during the 2nd CC word -> next output IDLE_WORD, cc_active=0; next burst starts 20 cycles after release.
REQ-037 Rebuild without AURORA_TX_CLK_COMP_EN, 100 cycles of continuous data -> 100 consecutive SRC_DATA words, cc_active never 1.
